lif_neuron_update: RTL

Leaky integrate-and-fire update stage directly downstream of the synaptic accumulator. It takes the 128 × 4-bit accumulated currents, integrates them into per-neuron membrane potentials, and compares each potential against the shared voltage threshold. Neurons that cross the threshold fire a spike and enter a refractory period whose length comes from the shared refractory-period register. The resulting 128-bit spike vector feeds the spike vector register file for the next layer/timestep.

---
 rtl/lif_neuron_update.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lif_neuron_update.sv
// Leaky integrate-and-fire update: integrates 128 snapshotted currents LANES per clock and emits a spike vector.
// Optional macro LIF_LEAK_EN enables the per-timestep leak subtractor.
module lif_neuron_update #(
  parameter int NUM_NEURONS = 128,
  parameter int LANES       = 16,
  parameter int VM_W        = 8,
  parameter int CUR_W       = 4,
  parameter int RP_W        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_NEURONS*CUR_W-1:0] cur_in,
  input  logic [VM_W-1:0]              vth,
  input  logic [RP_W-1:0]              rpr,
  input  logic [VM_W-1:0]              leak,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_NEURONS-1:0]       spike_out,
  output logic [7:0]                   spike_count,
  input  logic [6:0]                   vm_rd_idx,
  output logic [VM_W-1:0]              vm_rd_data
);

  localparam int NCHUNK = NUM_NEURONS / LANES;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int SW     = VM_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [KW-1:0]                  k;
  logic [NUM_NEURONS*CUR_W-1:0]   cur_snap;
  logic [VM_W-1:0]                vth_snap;
  logic [RP_W-1:0]                rpr_snap;
  logic [VM_W-1:0]                vm   [NUM_NEURONS];
  logic [RP_W-1:0]                refr [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]         shadow, shadow_next;
  logic [7:0]                     count_next;
  logic                           last_chunk;

  logic [IW-1:0]                  lane_idx      [LANES];
  logic [CUR_W-1:0]               lane_cur      [LANES];
  logic [VM_W-1:0]                lane_vm_old   [LANES];
  logic [RP_W-1:0]                lane_refr_old [LANES];
  logic signed [SW-1:0]           lane_sum      [LANES];
  logic [VM_W-1:0]                lane_clamp    [LANES];
  logic [VM_W-1:0]                lane_vm_new   [LANES];
  logic [RP_W-1:0]                lane_refr_new [LANES];
  logic [LANES-1:0]               lane_spk;

`ifdef LIF_LEAK_EN
  logic [VM_W-1:0]                leak_snap;
`else
  logic                           unused_leak;
  assign unused_leak = ^leak;
`endif

  assign last_chunk = (k == KW'(NCHUNK - 1));
  assign busy       = (state == RUN) || (state == DONE);
  assign done       = (state == DONE);
  assign vm_rd_data = vm[vm_rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One chunk of lanes: refractory neurons are held at zero, others integrate with a clamped sum.
  always_comb begin
    lane_spk = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_idx[j]      = IW'(int'(k) * LANES + j);
      lane_cur[j]      = cur_snap[lane_idx[j]*CUR_W +: CUR_W];
      lane_vm_old[j]   = vm[lane_idx[j]];
      lane_refr_old[j] = refr[lane_idx[j]];
`ifdef LIF_LEAK_EN
      lane_sum[j] = $signed({2'b00, lane_vm_old[j]})
                  + $signed({{(SW-CUR_W){1'b0}}, lane_cur[j]})
                  - $signed({2'b00, leak_snap});
`else
      lane_sum[j] = $signed({2'b00, lane_vm_old[j]})
                  + $signed({{(SW-CUR_W){1'b0}}, lane_cur[j]});
`endif
      if (lane_sum[j][SW-1])      lane_clamp[j] = '0;
      else if (lane_sum[j][VM_W]) lane_clamp[j] = '1;
      else                        lane_clamp[j] = lane_sum[j][VM_W-1:0];

      lane_vm_new[j]   = lane_clamp[j];
      lane_refr_new[j] = lane_refr_old[j];
      if (lane_refr_old[j] != '0) begin
        lane_refr_new[j] = lane_refr_old[j] - 1'b1;
        lane_vm_new[j]   = '0;
      end else if ((vth_snap != '0) && (lane_clamp[j] >= vth_snap)) begin
        lane_spk[j]      = 1'b1;
        lane_vm_new[j]   = '0;
        lane_refr_new[j] = rpr_snap;
      end
    end
  end

  always_comb begin
    shadow_next = shadow;
    for (int j = 0; j < LANES; j++) shadow_next[lane_idx[j]] = lane_spk[j];
    count_next = '0;
    for (int i = 0; i < NUM_NEURONS; i++) count_next = count_next + 8'(shadow_next[i]);
  end

  // Snapshot on start, write back one chunk per RUN cycle, publish the spike vector entering DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k           <= '0;
      cur_snap    <= '0;
      vth_snap    <= '0;
      rpr_snap    <= '0;
      shadow      <= '0;
      spike_out   <= '0;
      spike_count <= '0;
`ifdef LIF_LEAK_EN
      leak_snap   <= '0;
`endif
      for (int i = 0; i < NUM_NEURONS; i++) begin
        vm[i]   <= '0;
        refr[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_snap <= cur_in;
            vth_snap <= vth;
            rpr_snap <= rpr;
`ifdef LIF_LEAK_EN
            leak_snap <= leak;
`endif
            k <= '0;
          end
        end
        RUN: begin
          for (int j = 0; j < LANES; j++) begin
            vm[lane_idx[j]]   <= lane_vm_new[j];
            refr[lane_idx[j]] <= lane_refr_new[j];
          end
          shadow <= shadow_next;
          k      <= k + 1'b1;
          if (last_chunk) begin
            spike_out   <= shadow_next;
            spike_count <= count_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
